// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Holds default widths, register-file constants, requester indices and the
// two-way round-robin grant helper used by the arbiter.
package regfile_arb_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH;
  localparam int unsigned REG_ZERO   = 0;

  // Requester indices; also the encoding of the last-grant pointer.
  localparam bit REQ_ALU = 1'b0;
  localparam bit REQ_MEM = 1'b1;

  // Round-robin pick between two requesters. Bit i of the result grants
  // requester i. On a tie the requester not granted last time wins.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic last_grant);
    logic [1:0] grant;
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: two requester handshakes (valid/ready/rd/data) plus the
// registered register-file write port (we/rd/data).
//   master : requester side - drives valid/rd/data, observes ready and the write port
//   slave  : arbiter side   - observes requests, drives ready and the write port
interface regfile_wb_arbiter_if #(
  parameter int unsigned AddrWidth = regfile_arb_pkg::ADDR_WIDTH,
  parameter int unsigned DataWidth = regfile_arb_pkg::DATA_WIDTH
);

  logic                 req0_valid;
  logic                 req0_ready;
  logic [AddrWidth-1:0] req0_rd;
  logic [DataWidth-1:0] req0_data;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [AddrWidth-1:0] req1_rd;
  logic [DataWidth-1:0] req1_data;

  logic                 we;
  logic [AddrWidth-1:0] rd;
  logic [DataWidth-1:0] data;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  we, rd, data
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output we, rd, data
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   set_i / set_idx_i      : mark a register as having a write in flight
//   clr_i / clr_idx_i      : the write to that register commits this edge
//   rs_i/rt_i -> *_busy_o  : combinational lookups for decode
module regfile_scoreboard
  import regfile_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 set_i,
  input  logic [AddrWidth-1:0] set_idx_i,
  input  logic                 clr_i,
  input  logic [AddrWidth-1:0] clr_idx_i,
  input  logic [AddrWidth-1:0] rs_i,
  input  logic [AddrWidth-1:0] rt_i,
  output logic                 rs_busy_o,
  output logic                 rt_busy_o
);

  localparam int unsigned NumRegs = 1 << AddrWidth;

  logic [NumRegs-1:0] busy_q, busy_d;

  // Clear first, then set, so a new issue to the committing register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_i) begin
      busy_d[set_idx_i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Reset is synchronous, so mask lookups while it is held.
  assign rs_busy_o = rst_ni & busy_q[rs_i];
  assign rt_busy_o = rst_ni & busy_q[rt_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the 32-entry register file's single write port.
// Round-robin arbitrates between the ALU (req0) and memory (req1) requesters,
// registers the winning write one cycle before the register file commits it,
// and tracks in-flight destinations so decode can stall on rs/rt.
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   wb                        : requester handshakes and registered write port
//   issue_valid_i/issue_rd_i  : destination of an instruction issued this cycle
//   rs_i/rt_i                 : decode operand addresses
//   rs_busy_o/rt_busy_o       : operand still has an uncommitted write
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter int unsigned DataWidth = DATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  regfile_wb_arbiter_if.slave    wb,
  input  logic                   issue_valid_i,
  input  logic [AddrWidth-1:0]   issue_rd_i,
  input  logic [AddrWidth-1:0]   rs_i,
  input  logic [AddrWidth-1:0]   rt_i,
  output logic                   rs_busy_o,
  output logic                   rt_busy_o
);

  logic [1:0]           valid;
  logic [1:0]           grant;
  logic                 last_grant_q, last_grant_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] rd_q, rd_d;
  logic [DataWidth-1:0] data_q, data_d;

  assign valid = {wb.req1_valid, wb.req0_valid};

  // Ready only ever goes to a valid requester, so ready alone marks a handshake.
  always_comb begin
    grant = 2'b00;
    if (rst_ni) begin
      grant = rr_grant(valid, last_grant_q);
    end
  end

  assign wb.req0_ready = grant[REQ_ALU];
  assign wb.req1_ready = grant[REQ_MEM];

  // Writes to register zero are accepted but never enable the port.
  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    rd_d         = rd_q;
    data_d       = data_q;
    if (grant[REQ_ALU]) begin
      last_grant_d = REQ_ALU;
      we_d         = (wb.req0_rd != AddrWidth'(REG_ZERO));
      rd_d         = wb.req0_rd;
      data_d       = wb.req0_data;
    end else if (grant[REQ_MEM]) begin
      last_grant_d = REQ_MEM;
      we_d         = (wb.req1_rd != AddrWidth'(REG_ZERO));
      rd_d         = wb.req1_rd;
      data_d       = wb.req1_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= REQ_MEM;
      we_q         <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
    end
  end

  assign wb.we   = we_q;
  assign wb.rd   = rd_q;
  assign wb.data = data_q;

  // The busy bit clears on the commit edge, when we_q is high for rd_q.
  regfile_scoreboard #(
    .AddrWidth (AddrWidth)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .set_i     (issue_valid_i),
    .set_idx_i (issue_rd_i),
    .clr_i     (we_q),
    .clr_idx_i (rd_q),
    .rs_i      (rs_i),
    .rt_i      (rt_i),
    .rs_busy_o (rs_busy_o),
    .rt_busy_o (rt_busy_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_arb_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [ADDR_WIDTH-1:0] rs;
  logic [ADDR_WIDTH-1:0] rt;
  logic                  rs_busy;
  logic                  rt_busy;

  regfile_wb_arbiter_if #(
    .AddrWidth (ADDR_WIDTH),
    .DataWidth (DATA_WIDTH)
  ) wb ();

  regfile_wb_arbiter #(
    .AddrWidth (ADDR_WIDTH),
    .DataWidth (DATA_WIDTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wb            (wb),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rs_i          (rs),
    .rt_i          (rt),
    .rs_busy_o     (rs_busy),
    .rt_busy_o     (rt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: who should win, which registers await a write, and
  // which write the register-file port is presenting this cycle.
  bit          m_busy[NUM_REGS];
  int          m_last;
  bit          m_we;
  int          m_rd;
  logic [31:0] m_data;
  int          mdl_w;
  int          cmp_w;

  function automatic int exp_winner();
    if (!rst_n) return -1;
    if (wb.req0_valid && wb.req1_valid) return (m_last == 0) ? 1 : 0;
    if (wb.req0_valid) return 0;
    if (wb.req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_we   = 1'b0;
      m_rd   = 0;
      m_data = '0;
      m_last = 1;
      for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
    end else begin
      mdl_w = exp_winner();
      if (m_we) m_busy[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (mdl_w == 0) begin
        m_rd   = int'(wb.req0_rd);
        m_data = wb.req0_data;
      end else if (mdl_w == 1) begin
        m_rd   = int'(wb.req1_rd);
        m_data = wb.req1_data;
      end
      m_we = (mdl_w >= 0) && (m_rd != 0);
      if (mdl_w >= 0) m_last = mdl_w;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_w = exp_winner();
      chk("cmp_req0_ready", wb.req0_ready, cmp_w == 0);
      chk("cmp_req1_ready", wb.req1_ready, cmp_w == 1);
      chk("cmp_we", wb.we, m_we);
      chk("cmp_rd", wb.rd, m_rd);
      chk("cmp_data", wb.data, m_data);
      chk("cmp_rs_busy", rs_busy, rst_n && rs != 0 && m_busy[rs]);
      chk("cmp_rt_busy", rt_busy, rst_n && rt != 0 && m_busy[rt]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    issue_valid   = 1'b0;
    issue_rd      = '0;
    rs            = '0;
    rt            = '0;
    wb.req0_valid = 1'b0;
    wb.req0_rd    = '0;
    wb.req0_data  = '0;
    wb.req1_valid = 1'b0;
    wb.req1_rd    = '0;
    wb.req1_data  = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_we", wb.we, 0);
    chk("rst_rd", wb.rd, 0);
    chk("rst_data", wb.data, 0);

    // Single write to r1
    cyc(); issue_valid = 1'b1; issue_rd = 5'd1; rs = 5'd1;
    cyc(); issue_valid = 1'b0;
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd1; wb.req0_data = 32'd2001;
    @(negedge clk);
    chk("single_busy_before", rs_busy, 1);
    chk("single_ready0", wb.req0_ready, 1);
    cyc(); wb.req0_valid = 1'b0;
    @(negedge clk);
    chk("single_we", wb.we, 1);
    chk("single_rd", wb.rd, 1);
    chk("single_data", wb.data, 2001);
    chk("single_busy_until_commit", rs_busy, 1);
    cyc();
    @(negedge clk);
    chk("single_busy_after", rs_busy, 0);
    chk("single_we_off", wb.we, 0);

    // Register zero via req1
    cyc(); wb.req1_valid = 1'b1; wb.req1_rd = 5'd0; wb.req1_data = 32'd3001;
    issue_valid = 1'b1; issue_rd = 5'd0; rs = 5'd0;
    @(negedge clk);
    chk("r0_ready1", wb.req1_ready, 1);
    cyc(); wb.req1_valid = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    chk("r0_we", wb.we, 0);
    chk("r0_rs_busy", rs_busy, 0);

    // Continuous contention: req0, req1, req0, req1
    cyc();
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd2; wb.req0_data = 32'd4001;
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd6; wb.req1_data = 32'd5001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("cont_grant0", wb.req0_ready, (k % 2) == 0);
        chk("cont_grant1", wb.req1_ready, (k % 2) == 1);
      end
      if (k > 0) begin
        chk("cont_we", wb.we, 1);
        chk("cont_rd", wb.rd, (k % 2 == 1) ? 2 : 6);
        chk("cont_data", wb.data, (k % 2 == 1) ? 4001 : 5001);
      end
      cyc();
      if (k == 3) begin
        wb.req0_valid = 1'b0;
        wb.req1_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("cont_we_end", wb.we, 0);

    // Commit of r8 coinciding with a new issue to r8
    cyc(); issue_valid = 1'b1; issue_rd = 5'd8; rt = 5'd8;
    cyc(); issue_valid = 1'b0;
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd8; wb.req0_data = 32'd7001;
    @(negedge clk);
    chk("coll_rt_busy_pre", rt_busy, 1);
    chk("coll_ready0", wb.req0_ready, 1);
    cyc(); wb.req0_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd8;
    @(negedge clk);
    chk("coll_we", wb.we, 1);
    chk("coll_rd", wb.rd, 8);
    cyc(); issue_valid = 1'b0;
    @(negedge clk);
    chk("coll_rt_busy_kept", rt_busy, 1);
    cyc(); wb.req1_valid = 1'b1; wb.req1_rd = 5'd8; wb.req1_data = 32'd7002;
    @(negedge clk);
    chk("coll2_ready1", wb.req1_ready, 1);
    cyc(); wb.req1_valid = 1'b0;
    @(negedge clk);
    chk("coll2_data", wb.data, 7002);
    cyc();
    @(negedge clk);
    chk("coll2_rt_busy_clear", rt_busy, 0);

    // req1 withdraws before being granted
    cyc();
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd3; wb.req0_data = 32'd100;
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd9; wb.req1_data = 32'd200;
    @(negedge clk);
    chk("wd_ready0", wb.req0_ready, 1);
    chk("wd_ready1", wb.req1_ready, 0);
    cyc(); wb.req0_valid = 1'b0; wb.req1_valid = 1'b0;
    @(negedge clk);
    chk("wd_we", wb.we, 1);
    chk("wd_rd", wb.rd, 3);
    cyc();
    @(negedge clk);
    chk("wd_we_off", wb.we, 0);
    chk("wd_rd_hold", wb.rd, 3);
    chk("wd_data_hold", wb.data, 100);
    cyc();
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd4;  wb.req0_data = 32'd300;
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd10; wb.req1_data = 32'd400;
    @(negedge clk);
    chk("wd_ptr_ready1", wb.req1_ready, 1);
    chk("wd_ptr_ready0", wb.req0_ready, 0);
    cyc(); wb.req0_valid = 1'b0; wb.req1_valid = 1'b0;
    @(negedge clk);
    chk("wd_ptr_rd", wb.rd, 10);
    chk("wd_ptr_data", wb.data, 400);

    // Reset mid-stream with req0 valid and r5 pending
    cyc(); issue_valid = 1'b1; issue_rd = 5'd5; rs = 5'd5;
    cyc(); issue_valid = 1'b0;
    @(negedge clk);
    chk("rstm_busy5", rs_busy, 1);
    cyc(); rst_n = 1'b0;
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd11; wb.req0_data = 32'd900;
    @(negedge clk);
    chk("rstm_ready0_in_rst", wb.req0_ready, 0);
    chk("rstm_busy_in_rst", rs_busy, 0);
    cyc(); rst_n = 1'b1;
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd12; wb.req1_data = 32'd901;
    @(negedge clk);
    chk("rstm_we", wb.we, 0);
    chk("rstm_busy_lost", rs_busy, 0);
    chk("rstm_ready0_first", wb.req0_ready, 1);
    chk("rstm_ready1", wb.req1_ready, 0);
    cyc(); wb.req0_valid = 1'b0;
    @(negedge clk);
    chk("rstm_we_after", wb.we, 1);
    chk("rstm_rd_after", wb.rd, 11);
    chk("rstm_ready1_next", wb.req1_ready, 1);
    cyc(); wb.req1_valid = 1'b0;
    @(negedge clk);
    chk("rstm_rd_req1", wb.rd, 12);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the MIPS CPU's 32-entry register file, which has a single write port (data/we/rd). It shares that port between two write-back requesters: req0 (ALU path) and req1 (memory/load path). Arbitration is round-robin over a valid/ready handshake. A registered write stage drives the register file, and a pending-write scoreboard flags read operands (rs/rt) whose newest value has not yet been written, so the decode stage can stall on them.

## Interface
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width; the register count is 2^ADDR_WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid / req1_valid  in  1  requester has a write pending.
- req0_ready / req1_ready  out  1  requester is granted this cycle (combinational).
- req0_rd / req1_rd  in  ADDR_WIDTH  destination register.
- req0_data / req1_data  in  DATA_WIDTH  write value.
- issue_valid  in  1  an instruction with a destination was issued this cycle.
- issue_rd  in  ADDR_WIDTH  destination of the issued instruction.
- rs, rt  in  ADDR_WIDTH  operand addresses being read by decode.
- rs_busy, rt_busy  out  1  operand has an uncommitted pending write.
- we  out  1  register file write enable (registered).
- rd  out  ADDR_WIDTH  register file write address (registered).
- data  out  DATA_WIDTH  register file write data (registered).

## Operation
- **Grant:**
  - req_ready is asserted only to the winner and only while that requester's valid is high; at most one ready is high per cycle.
  - A handshake occurs when valid & ready.
- **Arbitration:**
  - If one requester is valid, it wins.
  - If both are valid, the one not granted most recently wins.
  - The last_grant pointer updates only on a handshake.
  - Out of reset, last_grant = 1, so req0 wins the first tie.
- **Requester stability:** while valid is high without ready, the requester holds rd/data stable. Dropping valid without a handshake is legal and leaves no side effects.
- **Write stage:** a handshake at edge E0 loads rd/data. we becomes 1 during the following cycle, and the register file commits at E1. With no handshake, we = 0 and rd/data hold their last values.
- **Register 0:**
  - A handshake with rd = 0 completes normally but produces we = 0.
  - issue_rd = 0 never sets a busy bit.
  - rs/rt = 0 always reports not busy.
- **Scoreboard:** one busy bit per register 1..2^ADDR_WIDTH−1.
  - Set on issue_valid with issue_rd ≠ 0.
  - Cleared on the edge where we = 1 for that rd, i.e., at commit.
  - The same register can be set and cleared on one edge; set wins.
  - Multiple outstanding writes to one register are not tracked. The first commit clears the bit, so issue must stall on a busy destination.
- **Busy outputs:** rs_busy = busy[rs], rt_busy = busy[rt]. These are combinational from the busy register, so they are low from the cycle after commit, when the register file already holds the new value.

## Timing
- **Reset values:** we = 0, rd = 0, data = 0, all busy = 0, last_grant = 1.
- **During reset:** req0_ready = req1_ready = 0 and rs_busy = rt_busy = 0.
- **Reset mid-operation:** the in-flight write is dropped (we = 0 after the reset edge) and all pending bits are lost.
- **Latency:**
  - Handshake to we = 1: one cycle.
  - Handshake to register value visible: two edges.
  - issue to busy visible: next cycle.
  - The first issue-to-ready path has no combinational loop.
- **Throughput:** one write per cycle. Back-to-back handshakes produce we high on consecutive cycles.
- **Fairness:** under continuous dual contention, grants strictly alternate.

## Structure
- Shared package regfile_arb_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - NUM_REGS = 1 << ADDR_WIDTH.
  - REG_ZERO = 0.
  - The requester index constants REQ_ALU = 0 and REQ_MEM = 1.
- One sub-module, regfile_scoreboard:
  - Holds the busy vector with its set/clear/priority logic.
  - Has two combinational lookup ports for rs/rt.
- The arbiter, the pointer and the write stage live in the top module.

## Test plan
- **Reset:** assert rst_n = 0 mid-stream with req0 valid and busy[5] set → the next cycle shows we = 0, both ready low, rs_busy = 0 for rs = 5. After release, req0 is granted first.
- **Single write:** issue_rd = 1, then req0 writes rd = 1, data = 2001 →
  - rs_busy (rs = 1) is high until the commit edge.
  - we = 1 with rd = 1, data = 2001 one cycle after the handshake.
  - rs_busy is low the next cycle.
- **Contention:** both requesters are valid for 4 cycles, req0 writing rd = 2, data = 4001 and req1 writing rd = 6, data = 5001, with each requester re-presenting after every grant → grants alternate req0, req1, req0, req1, and we stays high on 4 consecutive cycles.
- **Register 0:** req1 writes rd = 0, data = 3001 → ready handshake completes, we stays 0, and rs_busy (rs = 0) stays 0 even after issue_rd = 0.
- **Set/clear collision:** the commit of rd = 8 coincides with issue_valid, issue_rd = 8 → busy[8] remains 1 and rt_busy (rt = 8) stays high.
- **Valid withdrawal:** req1 raises valid while req0 is granted, then drops it before being granted → no write occurs and last_grant is unchanged.
